i2c_target: RTL and testbench

Clock-domain I2C target (slave) for the fpga9685 register interface. It replaces the SCL-clocked address shifter with a design that oversamples SCL/SDA on `clk_i`, detects START/STOP, matches a pin-strapped 7-bit address and ACKs it. It supports register-pointer writes, burst writes and burst reads with auto-increment, and drives SDA as open-drain. It sits between the board I2C pins and the PWM register file.

---
 rtl/i2c_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target for the PWM register file: oversampled SCL/SDA, 7-bit address match,
// register-pointer write, burst write and burst read with optional auto-increment.
module i2c_target #(
    parameter logic        ADDR_HI     = 1'b1,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AUTO_INC    = 1,
    localparam int unsigned REG_AW     = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        addr_pins_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic [REG_AW-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              ack_phase_q, ack_phase_d;
    logic              rw_q, rw_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;

    logic              scl_s, sda_s;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]        rx_byte;
    logic [REG_AW-1:0] ptr_wrap, ptr_inc;

    // Synchronizer chains: index 0 takes the pin, top index feeds event detection.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    assign rx_byte  = {rx_q, sda_s};
    assign ptr_wrap = (ptr_q == REG_AW'(NUM_REGS - 1)) ? '0 : ptr_q + REG_AW'(1);
    assign ptr_inc  = (AUTO_INC != 0) ? ptr_wrap : ptr_q;

    // Protocol FSM: bus conditions override every state, data sampled on scl_rise only.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ack_phase_d = ack_phase_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        oe_d        = oe_q;
        busy_d      = busy_q;

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            oe_d        = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            oe_d        = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        rx_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte[7:1] == {ADDR_HI, addr_pins_i}) begin
                                        state_d = ST_ADDR_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_PTR: begin
                                    if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                        ptr_d   = REG_AW'(rx_byte);
                                        state_d = ST_PTR_ACK;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
                                default: begin
                                    wdata_d = rx_byte;
                                    we_d    = 1'b1;
                                    state_d = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First fall after the byte pulls SDA low, the second releases it.
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            oe_d        = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            oe_d        = 1'b0;
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            case (state_q)
                                ST_ADDR_ACK: begin
                                    if (rw_q) begin
                                        tx_d    = {reg_rdata_i[6:0], 1'b1};
                                        oe_d    = ~reg_rdata_i[7];
                                        state_d = ST_RDATA;
                                    end else begin
                                        state_d = ST_PTR;
                                    end
                                end
                                ST_PTR_ACK: state_d = ST_WDATA;
                                default: begin
                                    ptr_d   = ptr_inc;
                                    state_d = ST_WDATA;
                                end
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    // MSB is already on the bus; each fall moves to the next bit.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            oe_d        = 1'b0;
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            state_d     = ST_RDATA_ACK;
                        end else begin
                            oe_d      = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (!sda_s) begin
                            ptr_d       = ptr_inc;
                            ack_phase_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        tx_d        = {reg_rdata_i[6:0], 1'b1};
                        oe_d        = ~reg_rdata_i[7];
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        state_d     = ST_RDATA;
                    end
                end
                ST_IGNORE: oe_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // Synchronizers reset to the idle-bus level so reset release is never a START.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_hist_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_hist_q  <= sda_hist_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ack_phase_q <= ack_phase_d;
            rw_q        <= rw_d;
            ptr_q       <= ptr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe_o    = oe_q;
    assign reg_addr_o  = ptr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged master on a shared open-drain bus
// with an auto-increment target at 0x45 and a fixed-pointer target at 0x47.
module tb_i2c_target;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic [5:0] pins_a = 6'h05;
    logic [5:0] pins_b = 6'h07;

    logic       oe_a, we_a, busy_a, oe_b, we_b, busy_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b, rdata_a, rdata_b;
    wire        sda_line = sda_m & ~oe_a & ~oe_b;

    assign rdata_a = {addr_a, 4'h0};
    assign rdata_b = {addr_b, 4'h0};

    i2c_target dut_a (
        .clk_i(clk), .rst_i(rst), .addr_pins_i(pins_a), .scl_i(scl), .sda_i(sda_line),
        .sda_oe_o(oe_a), .reg_addr_o(addr_a), .reg_wdata_o(wdata_a), .reg_we_o(we_a),
        .reg_rdata_i(rdata_a), .busy_o(busy_a)
    );

    i2c_target #(.AUTO_INC(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .addr_pins_i(pins_b), .scl_i(scl), .sda_i(sda_line),
        .sda_oe_o(oe_b), .reg_addr_o(addr_b), .reg_wdata_o(wdata_b), .reg_we_o(we_b),
        .reg_rdata_i(rdata_b), .busy_o(busy_b)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] wa_a[$], wa_b[$];
    logic [7:0] wd_a[$], wd_b[$];
    bit         oe_seen, busy_seen;

    // Write-strobe log and activity flags, sampled mid-cycle.
    always @(negedge clk) begin
        if (we_a) begin wa_a.push_back(addr_a); wd_a.push_back(wdata_a); end
        if (we_b) begin wa_b.push_back(addr_b); wd_b.push_back(wdata_b); end
        if (oe_a) oe_seen = 1'b1;
        if (busy_a) busy_seen = 1'b1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(8);
        scl   = 1'b1; tick(8);
        sda_m = 1'b0; tick(8);
        scl   = 1'b0; tick(8);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(8);
        scl   = 1'b1; tick(8);
        sda_m = 1'b1; tick(8);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(8);
        scl   = 1'b1; tick(8);
        scl   = 1'b0; tick(8);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(8);
        scl   = 1'b1; tick(4);
        b     = sda_line; tick(4);
        scl   = 1'b0; tick(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    task automatic test_reset();
        total++; if (oe_a !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b expected 0", oe_a); end
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL reset_we: got %b expected 0", we_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        total++; if (addr_a !== 4'h0) begin bad++; $display("FAIL reset_addr: got %h expected 0", addr_a); end
        total++; if (wdata_a !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h expected 00", wdata_a); end
    endtask

    task automatic test_write_burst();
        logic a0, a1, a2, a3;
        clear_logs();
        bus_start();
        write_byte(8'h8A, a0);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b expected 1", busy_a); end
        write_byte(8'h03, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        bus_stop();
        tick(4);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wr_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        total++; if (wa_a.size() !== 2) begin bad++; $display("FAIL wr_count: got %0d expected 2", wa_a.size()); end
        if (wa_a.size() == 2) begin
            total++; if (wa_a[0] !== 4'h3 || wd_a[0] !== 8'hA5) begin bad++; $display("FAIL wr_first: got %h=%h expected 3=a5", wa_a[0], wd_a[0]); end
            total++; if (wa_a[1] !== 4'h4 || wd_a[1] !== 8'h5A) begin bad++; $display("FAIL wr_second: got %h=%h expected 4=5a", wa_a[1], wd_a[1]); end
        end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL wr_busy_stop: got %b expected 0", busy_a); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        clear_logs();
        bus_start();
        write_byte(8'h8C, a0);
        write_byte(8'h12, a1);
        bus_stop();
        tick(4);
        total++; if ({a0, a1} !== 2'b00) begin bad++; $display("FAIL mis_acks: got %b expected 00", {a0, a1}); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL mis_oe: got %b expected 0", oe_seen); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL mis_busy: got %b expected 0", busy_seen); end
        total++; if (wa_a.size() + wa_b.size() !== 0) begin bad++; $display("FAIL mis_strobe: got %0d expected 0", wa_a.size() + wa_b.size()); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        clear_logs();
        bus_start();
        write_byte(8'h8A, a0); write_byte(8'h0F, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
        bus_stop();
        total++; if (wa_a.size() !== 2) begin bad++; $display("FAIL wrap_count: got %0d expected 2", wa_a.size()); end
        if (wa_a.size() == 2) begin
            total++; if (wa_a[0] !== 4'hF || wd_a[0] !== 8'h11) begin bad++; $display("FAIL wrap_first: got %h=%h expected f=11", wa_a[0], wd_a[0]); end
            total++; if (wa_a[1] !== 4'h0 || wd_a[1] !== 8'h22) begin bad++; $display("FAIL wrap_second: got %h=%h expected 0=22", wa_a[1], wd_a[1]); end
        end
        bus_start();
        write_byte(8'h8E, a0); write_byte(8'h0F, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
        bus_stop();
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL hold_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        total++; if (wa_b.size() !== 2) begin bad++; $display("FAIL hold_count: got %0d expected 2", wa_b.size()); end
        if (wa_b.size() == 2) begin
            total++; if (wa_b[0] !== 4'hF || wa_b[1] !== 4'hF || wd_b[1] !== 8'h22) begin bad++; $display("FAIL hold_addr: got %h,%h=%h expected f,f=22", wa_b[0], wa_b[1], wd_b[1]); end
        end
    endtask

    task automatic test_read_burst();
        logic a0, a1, a2;
        logic [7:0] d0, d1, d2;
        clear_logs();
        bus_start();
        write_byte(8'h8A, a0);
        write_byte(8'h02, a1);
        bus_start();
        write_byte(8'h8B, a2);
        read_byte(1'b1, d0);
        read_byte(1'b1, d1);
        read_byte(1'b0, d2);
        tick(2);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rd_acks: got %b expected 111", {a0, a1, a2}); end
        total++; if (d0 !== 8'h20) begin bad++; $display("FAIL rd_byte0: got %h expected 20", d0); end
        total++; if (d1 !== 8'h30) begin bad++; $display("FAIL rd_byte1: got %h expected 30", d1); end
        total++; if (d2 !== 8'h40) begin bad++; $display("FAIL rd_byte2: got %h expected 40", d2); end
        total++; if (oe_a !== 1'b0) begin bad++; $display("FAIL rd_release: got %b expected 0", oe_a); end
        total++; if (wa_a.size() !== 0) begin bad++; $display("FAIL rd_strobe: got %0d expected 0", wa_a.size()); end
        bus_stop();
        tick(4);
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rd_busy_stop: got %b expected 0", busy_a); end
    endtask

    task automatic test_bad_pointer();
        logic a0, a1, a2;
        clear_logs();
        bus_start();
        write_byte(8'h8A, a0);
        write_byte(8'h10, a1);
        write_byte(8'h99, a2);
        total++; if ({a0, a1, a2} !== 3'b100) begin bad++; $display("FAIL badptr_acks: got %b expected 100", {a0, a1, a2}); end
        total++; if (wa_a.size() !== 0) begin bad++; $display("FAIL badptr_strobe: got %0d expected 0", wa_a.size()); end
        bus_stop();
        bus_start();
        write_byte(8'h8A, a0); write_byte(8'h05, a1); write_byte(8'h3C, a2);
        bus_stop();
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL badptr_recover_acks: got %b expected 111", {a0, a1, a2}); end
        total++; if (wa_a.size() !== 1 || wa_a[0] !== 4'h5 || wd_a[0] !== 8'h3C) begin bad++; $display("FAIL badptr_recover: got %0d writes expected 1 at 5=3c", wa_a.size()); end
    endtask

    task automatic test_reset_midbyte();
        logic a0, a1, a2;
        clear_logs();
        bus_start();
        write_byte(8'h8A, a0);
        write_byte(8'h07, a1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        sda_m = 1'b1; tick(4);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        total++; if ({oe_a, we_a, busy_a} !== 3'b000) begin bad++; $display("FAIL rst_outs: got %b expected 000", {oe_a, we_a, busy_a}); end
        total++; if (addr_a !== 4'h0 || wdata_a !== 8'h00) begin bad++; $display("FAIL rst_regs: got %h/%h expected 0/00", addr_a, wdata_a); end
        tick(3);
        scl = 1'b1; tick(8);
        scl = 1'b0; tick(8);
        for (int i = 0; i < 3; i++) put_bit(1'b0);
        get_bit(a2);
        bus_stop();
        total++; if (a2 !== 1'b1) begin bad++; $display("FAIL rst_nack: got %b expected 1", a2); end
        total++; if (wa_a.size() !== 0) begin bad++; $display("FAIL rst_strobe: got %0d expected 0", wa_a.size()); end
        bus_start();
        write_byte(8'h8A, a0); write_byte(8'h01, a1); write_byte(8'h77, a2);
        bus_stop();
        total++; if (wa_a.size() !== 1 || wa_a[0] !== 4'h1 || wd_a[0] !== 8'h77) begin bad++; $display("FAIL rst_after: got %0d writes expected 1 at 1=77", wa_a.size()); end
    endtask

    initial begin
        tick(5);
        test_reset();
        rst = 1'b0;
        tick(5);
        test_write_burst();
        test_addr_mismatch();
        test_wrap();
        test_read_burst();
        test_bad_pointer();
        test_reset_midbyte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
